hazard_ctrl: RTL and testbench

//  Pipeline hazard controller; the consumer end of the execute stage's hazard interface.

---
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding selects, load-use / branch / memory-wait
// stall and flush strobes, a private M/W destination-register shadow, and saturating event counters.
module hazard_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic                 RegWriteE,
  input  logic                 MemReadE,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [CNT_WIDTH-1:0] LoadUseCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt,
  output logic [CNT_WIDTH-1:0] MemWaitCnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [4:0]           rd_m_q, rd_m_d, rd_w_q, rd_w_d;
  logic                 regwrite_m_q, regwrite_m_d;
  logic                 memread_m_q, memread_m_d;
  logic                 regwrite_w_q, regwrite_w_d;
  logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] memwait_cnt_q, memwait_cnt_d;

  logic memwait, lu;

  // A load in M has no ALU result to forward; its data arrives via W next cycle.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m, input logic mr_m,
                                         input logic [4:0] rd_w, input logic we_w);
    if (rs != 5'd0 && we_m && !mr_m && rd_m == rs) return 2'b10;
    else if (rs != 5'd0 && we_w && rd_w == rs)     return 2'b01;
    else                                           return 2'b00;
  endfunction

  assign memwait = MemReqM & ~MemReadyM;
  assign lu      = MemReadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  assign ForwardAE = fwd_sel(Rs1E, rd_m_q, regwrite_m_q, memread_m_q, rd_w_q, regwrite_w_q);
  assign ForwardBE = fwd_sel(Rs2E, rd_m_q, regwrite_m_q, memread_m_q, rd_w_q, regwrite_w_q);

  always_comb begin
    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (memwait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_comb begin
    rd_m_d       = rd_m_q;
    regwrite_m_d = regwrite_m_q;
    memread_m_d  = memread_m_q;
    rd_w_d       = rd_w_q;
    regwrite_w_d = 1'b0;
    if (!memwait) begin
      rd_m_d       = RdE;
      regwrite_m_d = RegWriteE;
      memread_m_d  = MemReadE;
      rd_w_d       = rd_m_q;
      regwrite_w_d = regwrite_m_q;
    end
  end

  always_comb begin
    lu_cnt_d      = lu_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    if (lu && !memwait && !PCSrcE && lu_cnt_q != CNT_MAX) lu_cnt_d = lu_cnt_q + CNT_ONE;
    if (PCSrcE && !memwait && flush_cnt_q != CNT_MAX)     flush_cnt_d = flush_cnt_q + CNT_ONE;
    if (memwait && memwait_cnt_q != CNT_MAX)              memwait_cnt_d = memwait_cnt_q + CNT_ONE;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_m_q        <= 5'd0;
      regwrite_m_q  <= 1'b0;
      memread_m_q   <= 1'b0;
      rd_w_q        <= 5'd0;
      regwrite_w_q  <= 1'b0;
      lu_cnt_q      <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      rd_m_q        <= rd_m_d;
      regwrite_m_q  <= regwrite_m_d;
      memread_m_q   <= memread_m_d;
      rd_w_q        <= rd_w_d;
      regwrite_w_q  <= regwrite_w_d;
      lu_cnt_q      <= lu_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign LoadUseCnt = lu_cnt_q;
  assign FlushCnt   = flush_cnt_q;
  assign MemWaitCnt = memwait_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl; a 16-bit and a 2-bit counter instance
// share all inputs and are compared every cycle against a slot-based reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic       RegWriteE, MemReadE, PCSrcE, MemReqM, MemReadyM;

  logic [1:0]  fa, fb, fa2, fb2;
  logic        sf, sd, se, sm, fd, fe;
  logic        sf2, sd2, se2, sm2, fd2, fe2;
  logic [15:0] lu_cnt, fl_cnt, mw_cnt;
  logic [1:0]  lu_cnt2, fl_cnt2, mw_cnt2;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ForwardAE(fa), .ForwardBE(fb), .StallF(sf), .StallD(sd),
    .StallE(se), .StallM(sm), .FlushD(fd), .FlushE(fe),
    .LoadUseCnt(lu_cnt), .FlushCnt(fl_cnt), .MemWaitCnt(mw_cnt)
  );

  hazard_ctrl #(.CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ForwardAE(fa2), .ForwardBE(fb2), .StallF(sf2), .StallD(sd2),
    .StallE(se2), .StallM(sm2), .FlushD(fd2), .FlushE(fe2),
    .LoadUseCnt(lu_cnt2), .FlushCnt(fl_cnt2), .MemWaitCnt(mw_cnt2)
  );

  // Reference model: the instruction occupying each later stage, plus raw event tallies.
  typedef struct {
    logic [4:0] rd;
    logic       we;
    logic       mr;
  } slot_t;

  slot_t m_slot, w_slot;
  int    lu_events, fl_events, mw_events;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] sat(input int n, input int width);
    int max_v;
    max_v = (1 << width) - 1;
    return (n > max_v) ? max_v : n;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (m_slot.we && !m_slot.mr && m_slot.rd == rs) return 2'b10;
    if (w_slot.we && w_slot.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_memwait();
    return MemReqM && !MemReadyM;
  endfunction

  function automatic logic model_lu();
    return MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  function automatic logic [5:0] model_ctl();
    if (model_memwait()) return 6'b111100;
    if (PCSrcE)          return 6'b000011;
    if (model_lu())      return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_slot = '{rd: 5'd0, we: 1'b0, mr: 1'b0};
    w_slot = '{rd: 5'd0, we: 1'b0, mr: 1'b0};
    lu_events = 0;
    fl_events = 0;
    mw_events = 0;
  endtask

  task automatic clear_in();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE} = '0;
    {RegWriteE, MemReadE, PCSrcE, MemReqM, MemReadyM} = '0;
  endtask

  task automatic rand_in();
    Rs1D      = 5'($urandom_range(0, 7));
    Rs2D      = 5'($urandom_range(0, 7));
    Rs1E      = 5'($urandom_range(0, 7));
    Rs2E      = 5'($urandom_range(0, 7));
    RdE       = 5'($urandom_range(0, 7));
    RegWriteE = 1'($urandom_range(0, 3) != 0);
    MemReadE  = 1'($urandom_range(0, 3) == 0);
    PCSrcE    = 1'($urandom_range(0, 7) == 0);
    MemReqM   = 1'($urandom_range(0, 2) == 0);
    MemReadyM = 1'($urandom_range(0, 1));
  endtask

  task automatic check_counters();
    check("lu_cnt",  32'(lu_cnt),  sat(lu_events, 16));
    check("fl_cnt",  32'(fl_cnt),  sat(fl_events, 16));
    check("mw_cnt",  32'(mw_cnt),  sat(mw_events, 16));
    check("lu_cnt2", 32'(lu_cnt2), sat(lu_events, 2));
    check("fl_cnt2", 32'(fl_cnt2), sat(fl_events, 2));
    check("mw_cnt2", 32'(mw_cnt2), sat(mw_events, 2));
  endtask

  task automatic check_all();
    check("fwd_a", 32'(fa), 32'(model_fwd(Rs1E)));
    check("fwd_b", 32'(fb), 32'(model_fwd(Rs2E)));
    check("ctl",   32'({sf, sd, se, sm, fd, fe}), 32'(model_ctl()));
    check("ctl2",  32'({sf2, sd2, se2, sm2, fd2, fe2, fa2, fb2}),
                   32'({model_ctl(), model_fwd(Rs1E), model_fwd(Rs2E)}));
    check_counters();
  endtask

  // Advance one cycle: the model retires the cycle's inputs at the edge, then waits for the falling edge.
  task automatic clock();
    logic mw, lu;
    @(posedge clk);
    mw = model_memwait();
    lu = model_lu();
    if (mw) mw_events++;
    if (PCSrcE && !mw) fl_events++;
    if (lu && !mw && !PCSrcE) lu_events++;
    if (mw) begin
      w_slot.we = 1'b0;
    end else begin
      w_slot = m_slot;
      m_slot = '{rd: RdE, we: RegWriteE, mr: MemReadE};
    end
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    check_all();
    clock();
  endtask

  int mw_before;

  initial begin
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rand_in();
    #1;
    check("rst_fwd_a", 32'(fa), 32'd0);
    check("rst_fwd_b", 32'(fb), 32'd0);
    check_counters();
    clear_in();
    #1 rst_n = 1'b1;
    clock();

    // EX->EX forward, then MEM->EX one cycle later.
    RdE = 5'd5; RegWriteE = 1'b1;
    step();
    clear_in(); Rs1E = 5'd5;
    #1 check("exex_fwd_a", 32'(fa), 32'b10);
    step();
    clear_in(); Rs2E = 5'd5;
    #1 check("memex_fwd_b", 32'(fb), 32'b01);
    step();

    // x0 never forwarded; M beats W for the same register.
    clear_in(); RdE = 5'd0; RegWriteE = 1'b1;
    step();
    clear_in(); Rs1E = 5'd0; RdE = 5'd7; RegWriteE = 1'b1;
    #1 check("x0_fwd_a", 32'(fa), 32'b00);
    step();
    clear_in(); RdE = 5'd7; RegWriteE = 1'b1;
    step();
    clear_in(); Rs1E = 5'd7;
    #1 check("prio_fwd_a", 32'(fa), 32'b10);
    step();

    // Load-use: one stall cycle, then the load result reaches E via W.
    clear_in(); MemReadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd3; Rs2D = 5'd3;
    #1 check("lu_ctl", 32'({sf, sd, se, sm, fd, fe}), 32'b110001);
    step();
    clear_in(); Rs2D = 5'd3;
    #1 check("lu_drop", 32'({sf, sd, fe}), 32'b000);
    check("lu_cnt_1", 32'(lu_cnt), 32'd1);
    step();
    clear_in(); Rs2E = 5'd3;
    #1 check("lu_fwd_b", 32'(fb), 32'b01);
    step();

    // Taken branch.
    clear_in(); PCSrcE = 1'b1;
    #1 check("br_ctl", 32'({sf, sd, se, sm, fd, fe}), 32'b000011);
    step();
    clear_in();
    #1 check("br_cnt", 32'(fl_cnt), 32'd1);
    step();

    // Memory wait hides a pending branch until it clears.
    mw_before = mw_events;
    for (int i = 0; i < 4; i++) begin
      clear_in(); MemReqM = 1'b1; PCSrcE = 1'b1; RdE = 5'd9; RegWriteE = 1'b1;
      #1 check("mw_ctl", 32'({sf, sd, se, sm, fd, fe}), 32'b111100);
      step();
    end
    clear_in(); MemReqM = 1'b1; MemReadyM = 1'b1; PCSrcE = 1'b1;
    #1 check("mw_cnt_4", 32'(mw_cnt), 32'(mw_before + 4));
    check("mw_release", 32'({sf, sd, se, sm, fd, fe}), 32'b000011);
    step();

    // Saturation of the 2-bit instance.
    for (int i = 0; i < 5; i++) begin
      clear_in(); MemReqM = 1'b1;
      step();
    end
    clear_in();
    #1 check("mw_sat2", 32'(mw_cnt2), 32'd3);
    step();

    // Random traffic with an occasional reset landing in the middle of a memory stall.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      if (i % 700 == 350) begin
        MemReqM = 1'b1; MemReadyM = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
